// File: rtl/fighter_anim_ctrl_if.sv
// Bus between game logic / pixel path and one fighter's animation sequencer.
// Requests are plain levels with no ready: a request is taken on the first cycle it is
// the highest-priority legal one, and busy rising one cycle later is the acknowledgement.
interface fighter_anim_ctrl_if;
   logic        frame_tick;
   logic        punch_req;
   logic        kick_req;
   logic        hit_req;
   logic        ko_req;
   logic [5:0]  sprite_x;
   logic [5:0]  sprite_y;
   logic [2:0]  anim_state;
   logic [1:0]  frame_idx;
   logic [13:0] rom_addr;
   logic        attack_active;
   logic        busy;
   logic        done;

   modport master (
      output frame_tick, punch_req, kick_req, hit_req, ko_req, sprite_x, sprite_y,
      input  anim_state, frame_idx, rom_addr, attack_active, busy, done
   );

   modport slave (
      input  frame_tick, punch_req, kick_req, hit_req, ko_req, sprite_x, sprite_y,
      output anim_state, frame_idx, rom_addr, attack_active, busy, done
   );
endinterface

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer: picks animation/frame each VGA frame and forms the
// registered sprite ROM address plus the attack-window flag used by hit detection.
module fighter_anim_ctrl #(
   parameter int FRAME_HOLD   = 6,
   parameter int IDLE_FRAMES  = 2,
   parameter int PUNCH_FRAMES = 3,
   parameter int KICK_FRAMES  = 4,
   parameter int HURT_FRAMES  = 2,
   parameter int DEAD_FRAMES  = 3,
   parameter int ATK_FRAME    = 1
) (
   input logic                 vga_clk,
   input logic                 reset_n,
   fighter_anim_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PUNCH = 3'd1,
      ST_KICK  = 3'd2,
      ST_HURT  = 3'd3,
      ST_DEAD  = 3'd4
   } anim_state_t;

   localparam logic [3:0] HOLD_LAST  = 4'(FRAME_HOLD - 1);
   localparam logic [1:0] IDLE_LAST  = 2'(IDLE_FRAMES - 1);
   localparam logic [1:0] PUNCH_LAST = 2'(PUNCH_FRAMES - 1);
   localparam logic [1:0] KICK_LAST  = 2'(KICK_FRAMES - 1);
   localparam logic [1:0] HURT_LAST  = 2'(HURT_FRAMES - 1);
   localparam logic [1:0] DEAD_LAST  = 2'(DEAD_FRAMES - 1);
   localparam logic [1:0] ATK_IDX    = 2'(ATK_FRAME);

   anim_state_t state_q, state_d;
   logic [1:0]  frame_q, frame_d;
   logic [3:0]  hold_q, hold_d;
   logic        atk_q, atk_d;
   logic        done_q, done_d;
   logic [13:0] rom_q;
   logic        last_frame;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         frame_q <= 2'd0;
         hold_q  <= 4'd0;
         atk_q   <= 1'b0;
         done_q  <= 1'b0;
         rom_q   <= 14'd0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         hold_q  <= hold_d;
         atk_q   <= atk_d;
         done_q  <= done_d;
         rom_q   <= {frame_q, bus.sprite_y, bus.sprite_x};
      end
   end

   always_comb begin
      last_frame = 1'b1;
      case (state_q)
         ST_IDLE:  last_frame = (frame_q == IDLE_LAST);
         ST_PUNCH: last_frame = (frame_q == PUNCH_LAST);
         ST_KICK:  last_frame = (frame_q == KICK_LAST);
         ST_HURT:  last_frame = (frame_q == HURT_LAST);
         ST_DEAD:  last_frame = (frame_q == DEAD_LAST);
         default:  last_frame = 1'b1;
      endcase
   end

   // Acceptance overrides any tick in the same cycle, including an end-of-animation one.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      done_d  = 1'b0;

      if (bus.ko_req && state_q != ST_DEAD) begin
         state_d = ST_DEAD;
         frame_d = 2'd0;
         hold_d  = 4'd0;
      end else if (bus.hit_req && state_q != ST_DEAD) begin
         state_d = ST_HURT;
         frame_d = 2'd0;
         hold_d  = 4'd0;
      end else if (bus.kick_req && state_q == ST_IDLE) begin
         state_d = ST_KICK;
         frame_d = 2'd0;
         hold_d  = 4'd0;
      end else if (bus.punch_req && state_q == ST_IDLE) begin
         state_d = ST_PUNCH;
         frame_d = 2'd0;
         hold_d  = 4'd0;
      end else if (bus.frame_tick) begin
         if (hold_q == HOLD_LAST) begin
            hold_d = 4'd0;
            if (!last_frame) begin
               frame_d = frame_q + 2'd1;
            end else begin
               case (state_q)
                  ST_IDLE: frame_d = 2'd0;
                  ST_DEAD: frame_d = DEAD_LAST;
                  default: begin
                     state_d = ST_IDLE;
                     frame_d = 2'd0;
                     done_d  = 1'b1;
                  end
               endcase
            end
         end else begin
            hold_d = hold_q + 4'd1;
         end
      end

      atk_d = (state_d == ST_PUNCH || state_d == ST_KICK) && (frame_d == ATK_IDX);
   end

   assign bus.anim_state    = state_q;
   assign bus.frame_idx     = frame_q;
   assign bus.rom_addr      = rom_q;
   assign bus.attack_active = atk_q;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.done          = done_q;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed bench for fighter_anim_ctrl with FRAME_HOLD=2: a cycle-by-cycle vector
// table plus hand-written reset sequences.
module tb_fighter_anim_ctrl;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] T = 5'b00001;  // frame_tick
  localparam logic [4:0] P = 5'b00010;  // punch_req
  localparam logic [4:0] K = 5'b00100;  // kick_req
  localparam logic [4:0] H = 5'b01000;  // hit_req
  localparam logic [4:0] O = 5'b10000;  // ko_req

  typedef struct {
    logic [4:0]  req;
    logic [5:0]  sx;
    logic [5:0]  sy;
    logic [2:0]  st;
    logic [1:0]  fr;
    logic        atk;
    logic        dn;
    logic        chk_rom;
    logic [13:0] rom;
  } vec_t;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  fighter_anim_ctrl_if bus ();

  fighter_anim_ctrl #(.FRAME_HOLD(2)) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] req, input logic [5:0] sx, input logic [5:0] sy);
    bus.frame_tick = req[0];
    bus.punch_req  = req[1];
    bus.kick_req   = req[2];
    bus.hit_req    = req[3];
    bus.ko_req     = req[4];
    bus.sprite_x   = sx;
    bus.sprite_y   = sy;
  endtask

  task automatic add(input logic [4:0] req, input logic [2:0] st, input logic [1:0] fr,
                     input logic atk, input logic dn);
    vec_t v;
    v = '{req: req, sx: 6'd0, sy: 6'd0, st: st, fr: fr, atk: atk, dn: dn,
          chk_rom: 1'b0, rom: 14'd0};
    vecs.push_back(v);
  endtask

  task automatic add_rom(input logic [4:0] req, input logic [5:0] sx, input logic [5:0] sy,
                         input logic [13:0] rom, input logic [2:0] st, input logic [1:0] fr,
                         input logic atk, input logic dn);
    vec_t v;
    v = '{req: req, sx: sx, sy: sy, st: st, fr: fr, atk: atk, dn: dn,
          chk_rom: 1'b1, rom: rom};
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] fr,
                         input logic atk, input logic bsy, input logic dn);
    chk({tag, " anim_state"}, 16'(bus.anim_state), 16'(st));
    chk({tag, " frame_idx"}, 16'(bus.frame_idx), 16'(fr));
    chk({tag, " attack_active"}, 16'(bus.attack_active), 16'(atk));
    chk({tag, " busy"}, 16'(bus.busy), 16'(bsy));
    chk({tag, " done"}, 16'(bus.done), 16'(dn));
  endtask

  initial begin
    // idle loop: frame flips every 2 ticks
    add(T, 0, 0, 0, 0); add(T, 0, 1, 0, 0); add(T, 0, 1, 0, 0); add(T, 0, 0, 0, 0);
    add(T, 0, 0, 0, 0); add(T, 0, 1, 0, 0); add(T, 0, 1, 0, 0); add(T, 0, 0, 0, 0);
    // one-cycle punch, kick ignored while busy, done after 6th tick
    add(P, 1, 0, 0, 0); add(N, 1, 0, 0, 0); add(T, 1, 0, 0, 0); add(T, 1, 1, 1, 0);
    add_rom(K, 6'd5, 6'd2, 14'd4229, 1, 1, 1, 0);
    add(T, 1, 1, 1, 0); add(T, 1, 2, 0, 0); add(T, 1, 2, 0, 0); add(T, 0, 0, 0, 1);
    add(N, 0, 0, 0, 0);
    // full kick reaching frame 3, top-corner address
    add(K, 2, 0, 0, 0); add(T, 2, 0, 0, 0); add(T, 2, 1, 1, 0); add(T, 2, 1, 1, 0);
    add(T, 2, 2, 0, 0); add(T, 2, 2, 0, 0); add(T, 2, 3, 0, 0);
    add_rom(N, 6'd63, 6'd63, 14'd16383, 2, 3, 0, 0);
    add(T, 2, 3, 0, 0); add(T, 0, 0, 0, 1);
    add_rom(N, 6'd0, 6'd0, 14'd0, 0, 0, 0, 0);
    // kick interrupted at frame 2 by hit+punch; hit restart inside HURT
    add(K, 2, 0, 0, 0); add(T, 2, 0, 0, 0); add(T, 2, 1, 1, 0); add(T, 2, 1, 1, 0);
    add(T, 2, 2, 0, 0); add(H | P, 3, 0, 0, 0); add(T, 3, 0, 0, 0); add(H, 3, 0, 0, 0);
    add(T, 3, 0, 0, 0); add(T, 3, 1, 0, 0); add(T, 3, 1, 0, 0); add(T, 0, 0, 0, 1);
    add(N, 0, 0, 0, 0);
    // held punch is ignored while busy, then re-accepted straight after done
    add(P, 1, 0, 0, 0); add(P | T, 1, 0, 0, 0); add(P | T, 1, 1, 1, 0);
    add(P | T, 1, 1, 1, 0); add(P | T, 1, 2, 0, 0); add(P | T, 1, 2, 0, 0);
    add(P | T, 0, 0, 0, 1); add(P, 1, 0, 0, 0);
    // hit coincident with end-of-punch: no done
    add(T, 1, 0, 0, 0); add(T, 1, 1, 1, 0); add(T, 1, 1, 1, 0); add(T, 1, 2, 0, 0);
    add(T, 1, 2, 0, 0); add(H | T, 3, 0, 0, 0);
    add(T, 3, 0, 0, 0); add(T, 3, 1, 0, 0); add(T, 3, 1, 0, 0); add(T, 0, 0, 0, 1);
    // ko with a tick (tick dropped), death holds on frame 2, all requests ignored
    add(T, 0, 0, 0, 0); add(O | T, 4, 0, 0, 0);
    add(T, 4, 0, 0, 0); add(T, 4, 1, 0, 0); add(T, 4, 1, 0, 0); add(T, 4, 2, 0, 0);
    add(T, 4, 2, 0, 0); add(T, 4, 2, 0, 0); add(T, 4, 2, 0, 0); add(T, 4, 2, 0, 0);
    add(T, 4, 2, 0, 0); add(T, 4, 2, 0, 0);
    add(P | K | H | O | T, 4, 2, 0, 0); add(P | H | O, 4, 2, 0, 0);

    drive(N, 6'd0, 6'd0);
    reset_n = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset rom_addr", 16'(bus.rom_addr), 16'd0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].sx, vecs[i].sy);
      step();
      chk_all($sformatf("v%0d", i), vecs[i].st, vecs[i].fr, vecs[i].atk,
              vecs[i].st != 3'd0, vecs[i].dn);
      if (vecs[i].chk_rom)
        chk($sformatf("v%0d rom_addr", i), 16'(bus.rom_addr), 16'(vecs[i].rom));
    end

    // leave DEAD through reset, then reach PUNCH frame 1 with sprite_x=7
    drive(N, 6'd7, 6'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("dead reset", 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    step();
    drive(P, 6'd7, 6'd0);
    step();
    chk_all("punch restart", 1, 0, 0, 1, 0);
    drive(P | T, 6'd7, 6'd0);
    step();
    step();
    chk_all("punch f1", 1, 1, 1, 1, 0);
    chk("punch f1 rom_addr", 16'(bus.rom_addr), 16'd7);

    // asynchronous reset between edges, punch_req still held
    drive(P, 6'd7, 6'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 0, 0, 0);
    chk("async reset rom_addr", 16'(bus.rom_addr), 16'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk_all("held punch after reset", 1, 0, 0, 1, 0);
    chk("held punch rom_addr", 16'(bus.rom_addr), 16'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
